// File: rtl/pipes.sv
`default_nettype none
// ============================================================================
// Module      : pipes (package)
// Description : Shared pipeline memory types: access size encoding, bus
//               arbiter FSM states and the registered memory request record.
// Revision    : 1.0 - initial release
// ============================================================================
package pipes;

  // The registered request is sized for the widest supported bus; narrower
  // arbiter instances zero-extend into it and slice back out.
  localparam int c_MAX_ADDR_W = 64;
  localparam int c_MAX_DATA_W = 64;
  localparam int c_MAX_STRB_W = c_MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    MSize_8bits  = 2'd0,
    MSize_16bits = 2'd1,
    MSize_32bits = 2'd2,
    MSize_64bits = 2'd3
  } MemSizeType;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [c_MAX_ADDR_W-1:0] addr;
    logic                    write;
    MemSizeType              size;
    logic [c_MAX_STRB_W-1:0] strobe;
    logic [c_MAX_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Arbitrates the fetch and memory-stage requesters onto one
//               shared memory port. Memory stage wins by default; defining
//               BUS_ARB_RR_EN alternates between requesters when both are
//               pending. ADDR_W and DATA_W must not exceed 64.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import pipes::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  // fetch requester
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_ready,
  output logic [DATA_W-1:0]   iresp_data,
  // memory-stage requester
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic                dreq_write,
  input  MemSizeType          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_wdata,
  output logic                dresp_ready,
  output logic [DATA_W-1:0]   dresp_data,
  // shared memory port
  output logic                mreq_valid,
  output logic [ADDR_W-1:0]   mreq_addr,
  output logic                mreq_write,
  output MemSizeType          mreq_size,
  output logic [DATA_W/8-1:0] mreq_strobe,
  output logic [DATA_W-1:0]   mreq_wdata,
  input  logic                mresp_ready,
  input  logic [DATA_W-1:0]   mresp_data
);

  arb_state_t r_state, w_state_nxt;
  mem_req_t   r_req, w_req_nxt;
  // Set once the owner withdraws its request; the response is then dropped
  // even if the owner re-raises valid before memory answers.
  logic       r_flush, w_flush_nxt;
  logic       w_pick_d;
  logic       w_owner_valid;
  logic       w_resp_ok;
  logic       w_grant;

`ifdef BUS_ARB_RR_EN
  // 1 = memory stage was granted last, 0 = fetch was granted last.
  logic       r_last_d, w_last_d_nxt;
`endif

  // Next-state, request capture and response qualification.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_flush_nxt   = r_flush;
    w_pick_d      = 1'b0;
    w_owner_valid = 1'b0;
    w_resp_ok     = 1'b0;
`ifdef BUS_ARB_RR_EN
    w_last_d_nxt  = r_last_d;
`endif
    case (r_state)
      IDLE: begin
`ifdef BUS_ARB_RR_EN
        w_pick_d = dreq_valid && !(ireq_valid && r_last_d);
`else
        w_pick_d = dreq_valid;
`endif
        w_flush_nxt = 1'b0;
        if (w_pick_d) begin
          w_state_nxt      = GRANT_D;
          w_req_nxt.addr   = c_MAX_ADDR_W'(dreq_addr);
          w_req_nxt.write  = dreq_write;
          w_req_nxt.size   = dreq_size;
          w_req_nxt.strobe = c_MAX_STRB_W'(dreq_strobe);
          w_req_nxt.wdata  = c_MAX_DATA_W'(dreq_wdata);
`ifdef BUS_ARB_RR_EN
          w_last_d_nxt     = 1'b1;
`endif
        end else if (ireq_valid) begin
          w_state_nxt      = GRANT_I;
          w_req_nxt.addr   = c_MAX_ADDR_W'(ireq_addr);
          w_req_nxt.write  = 1'b0;
          w_req_nxt.size   = MSize_64bits;
          w_req_nxt.strobe = '0;
          w_req_nxt.wdata  = '0;
`ifdef BUS_ARB_RR_EN
          w_last_d_nxt     = 1'b0;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        w_owner_valid = (r_state == GRANT_D) ? dreq_valid : ireq_valid;
        w_resp_ok     = mresp_ready && w_owner_valid && !r_flush;
        if (!w_owner_valid) begin
          w_flush_nxt = 1'b1;
        end
        if (mresp_ready) begin
          w_state_nxt = IDLE;
          w_flush_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered request; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_flush  <= 1'b0;
`ifdef BUS_ARB_RR_EN
      r_last_d <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_flush  <= w_flush_nxt;
`ifdef BUS_ARB_RR_EN
      r_last_d <= w_last_d_nxt;
`endif
    end
  end

  // The memory port shows the captured request only while a grant is held.
  assign w_grant     = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign mreq_valid  = w_grant;
  assign mreq_addr   = w_grant ? r_req.addr[ADDR_W-1:0]    : '0;
  assign mreq_write  = w_grant ? r_req.write               : 1'b0;
  assign mreq_size   = w_grant ? r_req.size                : MSize_8bits;
  assign mreq_strobe = w_grant ? r_req.strobe[DATA_W/8-1:0] : '0;
  assign mreq_wdata  = w_grant ? r_req.wdata[DATA_W-1:0]   : '0;

  // Only the current owner sees the response, and data is zero otherwise.
  assign iresp_ready = w_resp_ok && (r_state == GRANT_I);
  assign dresp_ready = w_resp_ok && (r_state == GRANT_D);
  assign iresp_data  = iresp_ready ? mresp_data : '0;
  assign dresp_data  = dresp_ready ? mresp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter. Expected order
//               of the contended round follows BUS_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  import pipes::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
`ifdef BUS_ARB_RR_EN
  localparam bit c_RR = 1'b1;
`else
  localparam bit c_RR = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_ready;
  logic [DATA_W-1:0] iresp_data;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic              dreq_write;
  MemSizeType        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_wdata;
  logic              dresp_ready;
  logic [DATA_W-1:0] dresp_data;
  logic              mreq_valid;
  logic [ADDR_W-1:0] mreq_addr;
  logic              mreq_write;
  MemSizeType        mreq_size;
  logic [7:0]        mreq_strobe;
  logic [DATA_W-1:0] mreq_wdata;
  logic              mresp_ready;
  logic [DATA_W-1:0] mresp_data;

  int n_asserts = 0;
  int n_fail    = 0;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ready(iresp_ready), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_ready(dresp_ready), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_write(mreq_write),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_wdata(mreq_wdata),
    .mresp_ready(mresp_ready), .mresp_data(mresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dwrite();
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_1000;
    dreq_write  = 1'b1;
    dreq_size   = MSize_64bits;
    dreq_strobe = 8'hFF;
    dreq_wdata  = 64'hDEAD;
  endtask

  task automatic test_reset();
    reset = 1'b1; ireq_valid = 1'b0; ireq_addr = '0; dreq_valid = 1'b0;
    dreq_addr = '0; dreq_write = 1'b0; dreq_size = MSize_8bits;
    dreq_strobe = '0; dreq_wdata = '0; mresp_ready = 1'b0; mresp_data = '0;
    #2;
    n_asserts++;
    if (mreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mreq_valid: got %0b want 0", mreq_valid); end
    n_asserts++;
    if ({iresp_ready, dresp_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_resp_ready: got %b want 00", {iresp_ready, dresp_ready}); end
    n_asserts++;
    if (mreq_addr !== '0 || mreq_wdata !== '0) begin n_fail++; $display("FAIL reset_mreq_data: addr %0h wdata %0h want 0", mreq_addr, mreq_wdata); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_cycle: mreq_valid %0b want 0", mreq_valid); end
    cyc();
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b1 || mreq_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL fetch_grant: valid %0b addr %0h want 1 80000000", mreq_valid, mreq_addr); end
    n_asserts++;
    if (mreq_write !== 1'b0 || mreq_size !== MSize_64bits || mreq_strobe !== 8'h00) begin n_fail++; $display("FAIL fetch_attrs: write %0b size %0d strobe %0h want 0 3 0", mreq_write, mreq_size, mreq_strobe); end
    cyc(); cyc();
    mresp_ready = 1'b1; mresp_data = 64'h13;
    @(negedge clk);
    n_asserts++;
    if (iresp_ready !== 1'b1 || iresp_data !== 64'h13 || dresp_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_resp: iready %0b idata %0h dready %0b want 1 13 0", iresp_ready, iresp_data, dresp_ready); end
    cyc();
    mresp_ready = 1'b0; ireq_valid = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b0 || iresp_ready !== 1'b0 || iresp_data !== '0) begin n_fail++; $display("FAIL fetch_back_idle: mvalid %0b iready %0b idata %0h want 0 0 0", mreq_valid, iresp_ready, iresp_data); end
    cyc();
  endtask

  task automatic test_priority();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    drive_dwrite();
    cyc();
    mresp_ready = 1'b1; mresp_data = 64'h55;
    @(negedge clk);
    n_asserts++;
    if (mreq_write !== 1'b1 || mreq_addr !== 64'h8000_1000 || mreq_strobe !== 8'hFF || mreq_wdata !== 64'hDEAD) begin n_fail++; $display("FAIL prio_first_dmem: write %0b addr %0h strobe %0h wdata %0h", mreq_write, mreq_addr, mreq_strobe, mreq_wdata); end
    n_asserts++;
    if (dresp_ready !== 1'b1 || iresp_ready !== 1'b0 || dresp_data !== 64'h55) begin n_fail++; $display("FAIL prio_first_resp: dready %0b iready %0b ddata %0h want 1 0 55", dresp_ready, iresp_ready, dresp_data); end
    cyc();
    mresp_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap: mreq_valid %0b want 0", mreq_valid); end
    cyc();
    mresp_ready = 1'b1; mresp_data = 64'h66;
    @(negedge clk);
    n_asserts++;
    if (mreq_write !== !c_RR) begin n_fail++; $display("FAIL prio_second_owner: mreq_write %0b want %0b", mreq_write, !c_RR); end
    n_asserts++;
    if (iresp_ready !== c_RR || dresp_ready !== !c_RR) begin n_fail++; $display("FAIL prio_second_resp: iready %0b dready %0b want %0b %0b", iresp_ready, dresp_ready, c_RR, !c_RR); end
    cyc();
    mresp_ready = 1'b0; dreq_valid = 1'b0;
    cyc();
    mresp_ready = 1'b1; mresp_data = 64'h77;
    @(negedge clk);
    n_asserts++;
    if (mreq_write !== 1'b0 || mreq_addr !== 64'h8000_0000 || iresp_ready !== 1'b1 || iresp_data !== 64'h77) begin n_fail++; $display("FAIL prio_fetch_last: write %0b addr %0h iready %0b idata %0h", mreq_write, mreq_addr, iresp_ready, iresp_data); end
    cyc();
    mresp_ready = 1'b0; ireq_valid = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    cyc();
    cyc();
    ireq_valid = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b1 || iresp_ready !== 1'b0) begin n_fail++; $display("FAIL flush_hold: mvalid %0b iready %0b want 1 0", mreq_valid, iresp_ready); end
    cyc();
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b1 || mreq_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL flush_hold2: mvalid %0b addr %0h want 1 80000000", mreq_valid, mreq_addr); end
    cyc();
    mresp_ready = 1'b1; mresp_data = 64'h99;
    @(negedge clk);
    n_asserts++;
    if (iresp_ready !== 1'b0 || iresp_data !== '0 || dresp_ready !== 1'b0) begin n_fail++; $display("FAIL flush_suppress: iready %0b idata %0h dready %0b want 0 0 0", iresp_ready, iresp_data, dresp_ready); end
    cyc();
    mresp_ready = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_end: mreq_valid %0b want 0", mreq_valid); end
    cyc();
  endtask

  task automatic test_addr_hold();
    drive_dwrite();
    cyc();
    dreq_addr = '0; dreq_wdata = '0; dreq_strobe = 8'h01;
    @(negedge clk);
    n_asserts++;
    if (mreq_addr !== 64'h8000_1000 || mreq_wdata !== 64'hDEAD || mreq_strobe !== 8'hFF) begin n_fail++; $display("FAIL hold_addr: addr %0h wdata %0h strobe %0h want 80001000 dead ff", mreq_addr, mreq_wdata, mreq_strobe); end
    cyc();
    mresp_ready = 1'b1; mresp_data = 64'hAA;
    @(negedge clk);
    n_asserts++;
    if (mreq_addr !== 64'h8000_1000 || dresp_ready !== 1'b1 || dresp_data !== 64'hAA) begin n_fail++; $display("FAIL hold_resp: addr %0h dready %0b ddata %0h", mreq_addr, dresp_ready, dresp_data); end
    cyc();
    mresp_ready = 1'b0; dreq_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    drive_dwrite();
    cyc();
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: mreq_valid %0b want 1", mreq_valid); end
    cyc();
    reset = 1'b1; mresp_ready = 1'b1; mresp_data = 64'hBB;
    #1;
    n_asserts++;
    if (mreq_valid !== 1'b0 || dresp_ready !== 1'b0 || mreq_addr !== '0) begin n_fail++; $display("FAIL rstmid_async: mvalid %0b dready %0b addr %0h want 0 0 0", mreq_valid, dresp_ready, mreq_addr); end
    dreq_valid = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b0 || dresp_ready !== 1'b0 || iresp_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: mvalid %0b dready %0b iready %0b want 0 0 0", mreq_valid, dresp_ready, iresp_ready); end
    mresp_ready = 1'b0;
    cyc();
  endtask

  task automatic test_spurious();
    mresp_ready = 1'b1; mresp_data = 64'hAB;
    @(negedge clk);
    n_asserts++;
    if ({iresp_ready, dresp_ready, mreq_valid} !== 3'b000 || iresp_data !== '0 || dresp_data !== '0) begin n_fail++; $display("FAIL spurious: iready %0b dready %0b mvalid %0b idata %0h ddata %0h", iresp_ready, dresp_ready, mreq_valid, iresp_data, dresp_data); end
    cyc();
    mresp_ready = 1'b0;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0040;
    cyc();
    @(negedge clk);
    n_asserts++;
    if (mreq_valid !== 1'b1 || mreq_addr !== 64'h8000_0040 || iresp_ready !== 1'b0) begin n_fail++; $display("FAIL spurious_after: mvalid %0b addr %0h iready %0b want 1 80000040 0", mreq_valid, mreq_addr, iresp_ready); end
    cyc();
    mresp_ready = 1'b1; mresp_data = 64'hCD;
    @(negedge clk);
    n_asserts++;
    if (iresp_ready !== 1'b1 || iresp_data !== 64'hCD) begin n_fail++; $display("FAIL spurious_after_resp: iready %0b idata %0h want 1 cd", iresp_ready, iresp_data); end
    cyc();
    mresp_ready = 1'b0; ireq_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_addr_hold();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
